coin_credit_dispenser: RTL and testbench

// - Money-side responder for the beverage vending control FSM.
// - Accumulates inserted-coin credit from en_cien/en_quin and returns m0..m4
//   (coin-reject and price-reached flags) to the FSM.
// - Services the FSM's vuelto / rst_cuenta requests by ejecting coins, one at
//   a time, through a valid/ready handshake to the coin ejector.
// - Units: 1 unit = 100 coin; a 500 coin = 5 units; prices 3/4/5/7 units.

---
 rtl/coin_credit_dispenser_if.sv | 30 +++
 rtl/coin_credit_dispenser.sv | 136 +++++++++++++
 tb/tb_coin_credit_dispenser.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coin_credit_dispenser_if.sv
// coin_credit_dispenser_if: credit, price-flag and coin-ejector signals between the vending FSM and the money side
interface coin_credit_dispenser_if;
    logic       en_cien;
    logic       en_quin;
    logic       vuelto;
    logic       producto;
    logic       rst_cuenta;
    logic [7:0] valor_producto;
    logic       coin_ready;
    logic [7:0] credit;
    logic       m0;
    logic       m1;
    logic       m2;
    logic       m3;
    logic       m4;
    logic       coin_valid;
    logic       coin_type;
    logic       busy;
    logic       done;

    modport master (
        output en_cien, en_quin, vuelto, producto, rst_cuenta, valor_producto, coin_ready,
        input  credit, m0, m1, m2, m3, m4, coin_valid, coin_type, busy, done
    );

    modport slave (
        input  en_cien, en_quin, vuelto, producto, rst_cuenta, valor_producto, coin_ready,
        output credit, m0, m1, m2, m3, m4, coin_valid, coin_type, busy, done
    );
endinterface

// File: rtl/coin_credit_dispenser.sv
// coin_credit_dispenser: accumulates coin credit and ejects change/refunds one coin at a time
module coin_credit_dispenser #(
    parameter int MAX_CREDIT = 20,
    parameter int QUIN_VAL   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    coin_credit_dispenser_if.slave dsp_if
);
    localparam logic [7:0] MAX_C = 8'(MAX_CREDIT);
    localparam logic [7:0] QV    = 8'(QUIN_VAL);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD     = 3'd1;
    localparam logic [2:0] ISSUE    = 3'd2;
    localparam logic [2:0] WAIT_ACK = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    logic [2:0] state_q, state_d;
    logic [7:0] credit_q, credit_d;
    logic [7:0] remaining_q, remaining_d;
    logic       coin_valid_q, coin_valid_d;
    logic       coin_type_q, coin_type_d;
    logic       done_q, done_d;
    logic       rej_valid_q, rej_valid_d;
    logic       rej_type_q, rej_type_d;
    logic       ret_rej_q, ret_rej_d;
    logic       vuelto_q;

    logic       m0;
    logic       vuelto_edge;
    logic       start;
    logic [7:0] owed;
    logic [7:0] start_amt;

    assign m0          = dsp_if.en_quin ? (credit_q > MAX_C - QV) : (dsp_if.en_cien && credit_q >= MAX_C);
    assign vuelto_edge = dsp_if.vuelto && !vuelto_q;
    assign start       = state_q == IDLE && (vuelto_edge || dsp_if.rst_cuenta);
    assign owed        = credit_q > dsp_if.valor_producto ? credit_q - dsp_if.valor_producto : 8'd0;
    // A bare vuelto returns only the last rejected coin; the greedy issuer then emits exactly that coin.
    assign start_amt   = !vuelto_edge ? credit_q :
                         dsp_if.producto ? owed :
                         rej_valid_q ? (rej_type_q ? QV : 8'd1) : 8'd0;

    assign dsp_if.credit     = credit_q;
    assign dsp_if.m0         = m0;
    assign dsp_if.m1         = credit_q >= 8'd3;
    assign dsp_if.m2         = credit_q >= 8'd4;
    assign dsp_if.m3         = credit_q >= 8'd5;
    assign dsp_if.m4         = credit_q >= 8'd7;
    assign dsp_if.coin_valid = coin_valid_q;
    assign dsp_if.coin_type  = coin_type_q;
    assign dsp_if.busy       = state_q != IDLE;
    assign dsp_if.done       = done_q;

    // Next-state: coin accumulation in IDLE, then the load/issue/ack dispense loop.
    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        remaining_d  = remaining_q;
        coin_valid_d = coin_valid_q;
        coin_type_d  = coin_type_q;
        done_d       = 1'b0;
        rej_valid_d  = rej_valid_q;
        rej_type_d   = rej_type_q;
        ret_rej_d    = ret_rej_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LOAD;
                    remaining_d = start_amt;
                    ret_rej_d   = vuelto_edge && !dsp_if.producto && rej_valid_q;
                end else if (dsp_if.en_quin || dsp_if.en_cien) begin
                    if (m0) begin
                        rej_valid_d = 1'b1;
                        rej_type_d  = dsp_if.en_quin;
                    end else begin
                        credit_d = credit_q + (dsp_if.en_quin ? QV : 8'd1);
                    end
                end
            end
            LOAD: state_d = ISSUE;
            ISSUE: begin
                if (remaining_q == 8'd0) begin
                    state_d = DONE;
                end else begin
                    coin_valid_d = 1'b1;
                    coin_type_d  = remaining_q >= QV;
                    state_d      = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (dsp_if.coin_ready) begin
                    coin_valid_d = 1'b0;
                    remaining_d  = remaining_q - (coin_type_q ? QV : 8'd1);
                    state_d      = ISSUE;
                end
            end
            DONE: begin
                done_d      = 1'b1;
                rej_valid_d = 1'b0;
                ret_rej_d   = 1'b0;
                credit_d    = ret_rej_q ? credit_q : 8'd0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; the async reset drops an in-flight coin offer immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            credit_q     <= 8'd0;
            remaining_q  <= 8'd0;
            coin_valid_q <= 1'b0;
            coin_type_q  <= 1'b0;
            done_q       <= 1'b0;
            rej_valid_q  <= 1'b0;
            rej_type_q   <= 1'b0;
            ret_rej_q    <= 1'b0;
            vuelto_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            remaining_q  <= remaining_d;
            coin_valid_q <= coin_valid_d;
            coin_type_q  <= coin_type_d;
            done_q       <= done_d;
            rej_valid_q  <= rej_valid_d;
            rej_type_q   <= rej_type_d;
            ret_rej_q    <= ret_rej_d;
            vuelto_q     <= dsp_if.vuelto;
        end
    end
endmodule

// File: tb/tb_coin_credit_dispenser.sv
// tb_coin_credit_dispenser: scenario tasks with a coin scoreboard for coin_credit_dispenser
module tb_coin_credit_dispenser;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   mcredit;
    logic exp_q[$];
    logic got_q[$];

    coin_credit_dispenser_if bus_if ();

    coin_credit_dispenser #(.MAX_CREDIT(20), .QUIN_VAL(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .dsp_if(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push_expected(input int amt);
        int a;
        a = amt;
        while (a > 0) begin
            if (a >= 5) begin
                exp_q.push_back(1'b1);
                a -= 5;
            end else begin
                exp_q.push_back(1'b0);
                a -= 1;
            end
        end
    endfunction

    function automatic logic model_coin(input logic c, input logic q);
        logic rej;
        rej = q ? (mcredit + 5 > 20) : (c && mcredit + 1 > 20);
        if (!rej) mcredit += q ? 5 : (c ? 1 : 0);
        return rej;
    endfunction

    task automatic idle_inputs();
        bus_if.en_cien        = 1'b0;
        bus_if.en_quin        = 1'b0;
        bus_if.vuelto         = 1'b0;
        bus_if.producto       = 1'b0;
        bus_if.rst_cuenta     = 1'b0;
        bus_if.valor_producto = 8'd0;
        bus_if.coin_ready     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        mcredit = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic drive_coin(input logic c, input logic q, output logic m0_seen);
        @(negedge clk);
        bus_if.en_cien = c;
        bus_if.en_quin = q;
        #1;
        m0_seen = bus_if.m0;
        @(negedge clk);
        bus_if.en_cien = 1'b0;
        bus_if.en_quin = 1'b0;
    endtask

    task automatic service(input int delay, output int first_valid, output int done_cyc, output logic stable);
        int   held;
        logic was_valid;
        logic t;
        first_valid = -1;
        done_cyc    = -1;
        stable      = 1'b1;
        held        = 0;
        was_valid   = 1'b0;
        t           = 1'b0;
        got_q.delete();
        for (int cyc = 1; cyc <= 300 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (bus_if.done) done_cyc = cyc;
            if (bus_if.coin_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (was_valid && bus_if.coin_type !== t) stable = 1'b0;
                t = bus_if.coin_type;
                if (held >= delay) begin
                    bus_if.coin_ready = 1'b1;
                    got_q.push_back(bus_if.coin_type);
                    held      = 0;
                    was_valid = 1'b0;
                end else begin
                    bus_if.coin_ready = 1'b0;
                    held++;
                    was_valid = 1'b1;
                end
            end else begin
                if (was_valid) stable = 1'b0;
                bus_if.coin_ready = 1'b0;
                was_valid         = 1'b0;
            end
        end
        bus_if.coin_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] m;
        @(negedge clk);
        bus_if.en_cien        = 1'b1;
        bus_if.en_quin        = 1'b1;
        bus_if.vuelto         = 1'b1;
        bus_if.producto       = 1'b1;
        bus_if.rst_cuenta     = 1'b1;
        bus_if.valor_producto = 8'hff;
        bus_if.coin_ready     = 1'b1;
        rst = 1'b1;
        #1;
        m = {bus_if.m4, bus_if.m3, bus_if.m2, bus_if.m1, bus_if.m0};
        n_cmp++;
        if (bus_if.credit !== 8'd0) begin n_err++; $display("FAIL reset_credit: got %0d want 0", bus_if.credit); end
        n_cmp++;
        if (bus_if.coin_valid !== 1'b0) begin n_err++; $display("FAIL reset_coin_valid: got %b want 0", bus_if.coin_valid); end
        n_cmp++;
        if (bus_if.coin_type !== 1'b0) begin n_err++; $display("FAIL reset_coin_type: got %b want 0", bus_if.coin_type); end
        n_cmp++;
        if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
        n_cmp++;
        if (bus_if.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus_if.done); end
        n_cmp++;
        if (m !== 5'b0) begin n_err++; $display("FAIL reset_m4_m0: got %b want 00000", m); end
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        mcredit = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus_if.coin_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_coin_valid: got %b want 0 (cycle %0d)", bus_if.coin_valid, i); end
        end
    endtask

    task automatic test_accumulate();
        logic       c_seq[3] = '{1'b0, 1'b1, 1'b1};
        logic       q_seq[3] = '{1'b1, 1'b0, 1'b0};
        logic       seen;
        logic       want;
        logic [3:0] m;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            want = model_coin(c_seq[i], q_seq[i]);
            drive_coin(c_seq[i], q_seq[i], seen);
            n_cmp++;
            if (seen !== want) begin n_err++; $display("FAIL accum_m0[%0d]: got %b want %b", i, seen, want); end
        end
        n_cmp++;
        if (bus_if.credit !== 8'(mcredit)) begin n_err++; $display("FAIL accum_credit: got %0d want %0d", bus_if.credit, mcredit); end
        m = {bus_if.m4, bus_if.m3, bus_if.m2, bus_if.m1};
        n_cmp++;
        if (m !== 4'b1111) begin n_err++; $display("FAIL accum_m4_m1: got %b want 1111", m); end
    endtask

    task automatic test_change();
        int   fv;
        int   dc;
        logic st;
        logic e;
        logic g;
        logic stayed_idle;
        bus_if.valor_producto = 8'd3;
        bus_if.producto       = 1'b1;
        bus_if.vuelto         = 1'b1;
        push_expected(mcredit > 3 ? mcredit - 3 : 0);
        service(0, fv, dc, st);
        n_cmp++;
        if (fv !== 3) begin n_err++; $display("FAIL change_latency: got %0d want 3", fv); end
        n_cmp++;
        if (dc < 0) begin n_err++; $display("FAIL change_done: got timeout want pulse"); end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL change_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL change_coin_type: got %b want %b", g, e); end
        end
        exp_q.delete();
        mcredit = 0;
        n_cmp++;
        if (bus_if.credit !== 8'(mcredit)) begin n_err++; $display("FAIL change_credit: got %0d want %0d", bus_if.credit, mcredit); end
        stayed_idle = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus_if.busy !== 1'b0) stayed_idle = 1'b0;
        end
        n_cmp++;
        if (stayed_idle !== 1'b1) begin n_err++; $display("FAIL change_no_retrigger: got busy want idle"); end
        bus_if.vuelto   = 1'b0;
        bus_if.producto = 1'b0;
    endtask

    task automatic test_delayed_ack();
        logic c_seq[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic q_seq[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic seen;
        logic rej;
        int   fv;
        int   dc;
        logic st;
        logic e;
        logic g;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rej = model_coin(c_seq[i], q_seq[i]);
            drive_coin(c_seq[i], q_seq[i], seen);
        end
        n_cmp++;
        if (bus_if.credit !== 8'(mcredit)) begin n_err++; $display("FAIL delay_credit_in: got %0d want %0d", bus_if.credit, mcredit); end
        bus_if.valor_producto = 8'd4;
        bus_if.producto       = 1'b1;
        bus_if.vuelto         = 1'b1;
        push_expected(mcredit > 4 ? mcredit - 4 : 0);
        service(3, fv, dc, st);
        n_cmp++;
        if (dc < 0) begin n_err++; $display("FAIL delay_done: got timeout want pulse"); end
        n_cmp++;
        if (st !== 1'b1) begin n_err++; $display("FAIL delay_hold_stable: got %b want 1", st); end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL delay_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL delay_coin_type: got %b want %b", g, e); end
        end
        exp_q.delete();
        mcredit = 0;
        n_cmp++;
        if (bus_if.credit !== 8'(mcredit)) begin n_err++; $display("FAIL delay_credit_out: got %0d want %0d", bus_if.credit, mcredit); end
        bus_if.vuelto   = 1'b0;
        bus_if.producto = 1'b0;
    endtask

    task automatic test_reject();
        logic c_seq[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic q_seq[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic c_top[3] = '{1'b1, 1'b1, 1'b1};
        logic seen;
        logic want;
        int   fv;
        int   dc;
        logic st;
        logic e;
        logic g;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            want = model_coin(c_seq[i], q_seq[i]);
            drive_coin(c_seq[i], q_seq[i], seen);
        end
        n_cmp++;
        if (bus_if.credit !== 8'(mcredit)) begin n_err++; $display("FAIL rej_build_credit: got %0d want %0d", bus_if.credit, mcredit); end
        want = model_coin(1'b0, 1'b1);
        drive_coin(1'b0, 1'b1, seen);
        n_cmp++;
        if (seen !== want) begin n_err++; $display("FAIL rej_m0_quin: got %b want %b", seen, want); end
        n_cmp++;
        if (bus_if.credit !== 8'(mcredit)) begin n_err++; $display("FAIL rej_credit_kept: got %0d want %0d", bus_if.credit, mcredit); end
        bus_if.producto = 1'b0;
        bus_if.vuelto   = 1'b1;
        exp_q.push_back(1'b1);
        service(0, fv, dc, st);
        bus_if.vuelto = 1'b0;
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rej_return_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL rej_return_type: got %b want %b", g, e); end
        end
        exp_q.delete();
        n_cmp++;
        if (bus_if.credit !== 8'(mcredit)) begin n_err++; $display("FAIL rej_credit_after: got %0d want %0d", bus_if.credit, mcredit); end
        for (int i = 0; i < 3; i++) begin
            want = model_coin(c_top[i], 1'b0);
            drive_coin(c_top[i], 1'b0, seen);
            n_cmp++;
            if (seen !== want) begin n_err++; $display("FAIL rej_cap_m0[%0d]: got %b want %b", i, seen, want); end
        end
        n_cmp++;
        if (bus_if.credit !== 8'(mcredit)) begin n_err++; $display("FAIL rej_cap_credit: got %0d want %0d", bus_if.credit, mcredit); end
    endtask

    task automatic test_zero_owed();
        logic c_seq[3] = '{1'b1, 1'b1, 1'b1};
        logic seen;
        logic rej;
        int   fv;
        int   dc;
        logic st;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            rej = model_coin(c_seq[i], 1'b0);
            drive_coin(c_seq[i], 1'b0, seen);
        end
        bus_if.valor_producto = 8'd5;
        bus_if.producto       = 1'b1;
        bus_if.vuelto         = 1'b1;
        service(0, fv, dc, st);
        bus_if.vuelto   = 1'b0;
        bus_if.producto = 1'b0;
        n_cmp++;
        if (dc !== 4) begin n_err++; $display("FAIL zero_done_latency: got %0d want 4", dc); end
        n_cmp++;
        if (got_q.size() != 0) begin n_err++; $display("FAIL zero_coin_count: got %0d want 0", got_q.size()); end
        mcredit = 0;
        n_cmp++;
        if (bus_if.credit !== 8'(mcredit)) begin n_err++; $display("FAIL zero_credit: got %0d want %0d", bus_if.credit, mcredit); end
    endtask

    task automatic test_cancel();
        logic seen;
        logic rej;
        int   fv;
        int   dc;
        logic st;
        logic e;
        logic g;
        bit   offered;
        do_reset();
        rej = model_coin(1'b0, 1'b1);
        drive_coin(1'b0, 1'b1, seen);
        rej = model_coin(1'b1, 1'b0);
        drive_coin(1'b1, 1'b0, seen);
        bus_if.rst_cuenta = 1'b1;
        push_expected(mcredit);
        @(negedge clk);
        bus_if.rst_cuenta = 1'b0;
        service(0, fv, dc, st);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL cancel_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL cancel_coin_type: got %b want %b", g, e); end
        end
        exp_q.delete();
        mcredit = 0;
        n_cmp++;
        if (bus_if.credit !== 8'(mcredit)) begin n_err++; $display("FAIL cancel_credit: got %0d want %0d", bus_if.credit, mcredit); end
        rej = model_coin(1'b0, 1'b1);
        drive_coin(1'b0, 1'b1, seen);
        rej = model_coin(1'b1, 1'b0);
        drive_coin(1'b1, 1'b0, seen);
        bus_if.rst_cuenta = 1'b1;
        @(negedge clk);
        bus_if.rst_cuenta = 1'b0;
        offered = 1'b0;
        for (int i = 0; i < 10 && !offered; i++) begin
            @(negedge clk);
            if (bus_if.coin_valid) offered = 1'b1;
        end
        n_cmp++;
        if (offered !== 1'b1) begin n_err++; $display("FAIL cancel_offer: got none want coin_valid"); end
        #2;
        rst = 1'b1;
        #1;
        mcredit = 0;
        n_cmp++;
        if (bus_if.coin_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_coin_valid: got %b want 0", bus_if.coin_valid); end
        n_cmp++;
        if (bus_if.credit !== 8'(mcredit)) begin n_err++; $display("FAIL rst_mid_credit: got %0d want %0d", bus_if.credit, mcredit); end
        n_cmp++;
        if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", bus_if.busy); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus_if.coin_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_release: got %b want 0", bus_if.coin_valid); end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        mcredit = 0;
        rst     = 1'b0;
        idle_inputs();
        #1;
        rst = 1'b1;
        test_reset();
        test_accumulate();
        test_change();
        test_delayed_ack();
        test_reject();
        test_zero_owed();
        test_cancel();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
